// File: rtl/mdu_pkg.sv
// Package for the MDU issue controller.
// Holds op-code constants, op-class helpers, the FSM state type and the
// default busy-cycle counts. Imported by mdu_cycle_counter and mdu_issue_ctrl.
package mdu_pkg;

  localparam logic [4:0] OP_NONE  = 5'd0;
  localparam logic [4:0] OP_MULT  = 5'd1;
  localparam logic [4:0] OP_MULTU = 5'd2;
  localparam logic [4:0] OP_DIV   = 5'd3;
  localparam logic [4:0] OP_DIVU  = 5'd4;
  localparam logic [4:0] OP_MFHI  = 5'd5;
  localparam logic [4:0] OP_MFLO  = 5'd6;
  localparam logic [4:0] OP_MTHI  = 5'd7;
  localparam logic [4:0] OP_MTLO  = 5'd8;
  localparam logic [4:0] OP_MSUB  = 5'd9;

  localparam int unsigned MUL_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF = 10;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_BUSY_MUL = 2'd1,
    S_BUSY_DIV = 2'd2
  } mdu_state_e;

  function automatic logic is_mul(input logic [4:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MSUB);
  endfunction

  function automatic logic is_div(input logic [4:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_move(input logic [4:0] op);
    return (op == OP_MFHI) || (op == OP_MFLO) ||
           (op == OP_MTHI) || (op == OP_MTLO);
  endfunction

  // Codes 10..31 decode as NONE, so only the defined classes count as real ops.
  function automatic logic is_op(input logic [4:0] op);
    return is_mul(op) || is_div(op) || is_move(op);
  endfunction

endpackage

// File: rtl/mdu_cycle_counter.sv
// Loadable 4-bit down-counter tracking remaining mult/div busy cycles.
// Ports:
//   clk, reset   : clock, synchronous active-high reset (count -> 0)
//   load/ld_val  : load ld_val this cycle (takes priority over dec)
//   dec          : decrement by one, saturating at 0
//   value        : current count
//   last         : value == 1 (final busy cycle)
module mdu_cycle_counter
  import mdu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] ld_val,
  input  logic       dec,
  output logic [3:0] value,
  output logic       last
);

  always_ff @(posedge clk) begin
    if (reset)
      value <= 4'd0;
    else if (load)
      value <= ld_val;
    else if (dec && (value != 4'd0))
      value <= value - 4'd1;
  end

  assign last = (value == 4'd1);

endmodule

// File: rtl/mdu_issue_ctrl.sv
// Issue controller / hazard scheduler for the multiply-divide unit.
// Decides which E-stage MDU op reaches the datapath, tracks multi-cycle
// mult/div occupancy, raises the D-stage stall and flags ops that arrive
// while the unit is busy (sticky conflict).
// Optional feature: define MDU_DIV0_FAST_EN to drop div-class ops whose
// divisor is zero instead of issuing them.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   int_exc_req  : interrupt/exception taken this cycle (blocks new issue)
//   e_op         : MDU op code of the E-stage instruction
//   d_is_mdu     : D-stage instruction is an MDU op
//   div_b_zero   : E-stage divisor is zero
//   mdu_op_o     : op presented to the datapath (NONE when suppressed)
//   start        : mult/div-class op issued this cycle
//   busy         : mult/div in flight
//   stall_d      : stall the D stage
//   conflict     : sticky protocol-violation flag
module mdu_issue_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       int_exc_req,
  input  logic [4:0] e_op,
  input  logic       d_is_mdu,
  input  logic       div_b_zero,
  output logic [4:0] mdu_op_o,
  output logic       start,
  output logic       busy,
  output logic       stall_d,
  output logic       conflict
);

  localparam logic [3:0] MUL_LD = 4'(MUL_CYCLES);
  localparam logic [3:0] DIV_LD = 4'(DIV_CYCLES);

  mdu_state_e state, state_nxt;
  logic       cnt_load;
  logic [3:0] cnt_ld_val;
  logic [3:0] cnt;
  logic       cnt_last;
  logic       viol;
  logic       div0_skip;

`ifdef MDU_DIV0_FAST_EN
  // Divide by zero leaves HI/LO untouched, so the op is simply not issued.
  assign div0_skip = div_b_zero;
`else
  assign div0_skip = div_b_zero & 1'b0;
`endif

  mdu_cycle_counter u_cnt (
    .clk    (clk),
    .reset  (reset),
    .load   (cnt_load),
    .ld_val (cnt_ld_val),
    .dec    (busy),
    .value  (cnt),
    .last   (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    start      = 1'b0;
    mdu_op_o   = OP_NONE;
    cnt_load   = 1'b0;
    cnt_ld_val = MUL_LD;
    viol       = 1'b0;
    case (state)
      S_IDLE: begin
        if (!int_exc_req) begin
          if (is_mul(e_op)) begin
            start      = 1'b1;
            mdu_op_o   = e_op;
            cnt_load   = 1'b1;
            cnt_ld_val = MUL_LD;
            state_nxt  = S_BUSY_MUL;
          end else if (is_div(e_op) && !div0_skip) begin
            start      = 1'b1;
            mdu_op_o   = e_op;
            cnt_load   = 1'b1;
            cnt_ld_val = DIV_LD;
            state_nxt  = S_BUSY_DIV;
          end else if (is_move(e_op)) begin
            mdu_op_o   = e_op;
          end
        end
      end
      S_BUSY_MUL, S_BUSY_DIV: begin
        // A correct D-stage stall keeps E empty; anything here is dropped.
        viol = is_op(e_op);
        // cnt==0 cannot occur while busy; treat it as done rather than hang.
        if (cnt_last || (cnt == 4'd0))
          state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)     conflict <= 1'b0;
    else if (viol) conflict <= 1'b1;
  end

  assign busy    = (state != S_IDLE);
  assign stall_d = d_is_mdu & (busy | start);

endmodule
